// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: FSM state encoding, weakly-not-taken
// counter value and the saturating counter step.
package bp_pkg;

  typedef enum logic {
    LHP_INIT,
    LHP_RUN
  } lhp_state_e;

  // Weakly-not-taken pattern 01..0 for a counter of cnt_w bits.
  function automatic logic [31:0] wnt_value(input int unsigned cnt_w);
    return 32'd1 << (cnt_w - 2);
  endfunction

  function automatic logic [31:0] sat_next(input logic [31:0] cnt,
                                           input logic        taken,
                                           input int unsigned cnt_w);
    logic [31:0] max_v;
    max_v = (cnt_w >= 32) ? '1 : ((32'd1 << cnt_w) - 32'd1);
    if (taken) return (cnt == max_v) ? cnt : cnt + 32'd1;
    return (cnt == '0) ? cnt : cnt - 32'd1;
  endfunction

endpackage

// File: rtl/local_hist_predictor_if.sv
// Lookup/response and resolved-branch update signals of the local history predictor.
interface local_hist_predictor_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned HIST_W = 6
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_taken;
  logic [HIST_W-1:0] resp_hist;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_addr;
  logic [HIST_W-1:0] upd_hist;
  logic              upd_taken;

  modport master (
    output req_valid, req_addr, upd_valid, upd_addr, upd_hist, upd_taken,
    input  resp_valid, resp_taken, resp_hist
  );

  modport slave (
    input  req_valid, req_addr, upd_valid, upd_addr, upd_hist, upd_taken,
    output resp_valid, resp_taken, resp_hist
  );
endinterface

// File: rtl/sat_counter_tbl.sv
// Pattern history table: saturating counters with init write and resolved update.
// LHP_BYPASS_EN forwards the counter being updated to a same-index read.
module sat_counter_tbl
  import bp_pkg::*;
#(
  parameter int unsigned HIST_W = 6,
  parameter int unsigned CNT_W  = 2
) (
  input  logic              clk,
  input  logic              init_we_i,
  input  logic [HIST_W-1:0] init_idx_i,
  input  logic              upd_we_i,
  input  logic [HIST_W-1:0] upd_idx_i,
  input  logic              upd_taken_i,
  input  logic [HIST_W-1:0] rd_idx_i,
  output logic              rd_taken_o
);
  localparam int unsigned PHT_NUM = 2 ** HIST_W;

  logic [CNT_W-1:0] pht_q [PHT_NUM];
  logic [CNT_W-1:0] upd_cnt_d;

  always_comb upd_cnt_d = CNT_W'(sat_next(32'(pht_q[upd_idx_i]), upd_taken_i, CNT_W));

  // Storage is deliberately not reset; the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (init_we_i) begin
      pht_q[init_idx_i] <= CNT_W'(wnt_value(CNT_W));
    end else if (upd_we_i) begin
      pht_q[upd_idx_i] <= upd_cnt_d;
    end
  end

`ifdef LHP_BYPASS_EN
  always_comb rd_taken_o = (upd_we_i && (upd_idx_i == rd_idx_i)) ? upd_cnt_d[CNT_W-1]
                                                                 : pht_q[rd_idx_i][CNT_W-1];
`else
  always_comb rd_taken_o = pht_q[rd_idx_i][CNT_W-1];
`endif

endmodule

// File: rtl/local_hist_predictor.sv
// Two-level local-history branch predictor: per-line history table indexing a
// shared PHT. Define LHP_BYPASS_EN to forward same-cycle updates to lookups.
module local_hist_predictor
  import bp_pkg::*;
#(
  parameter int unsigned LINE_NUM = 1024,
  parameter int unsigned HIST_W   = 6,
  parameter int unsigned CNT_W    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  output logic busy,
  local_hist_predictor_if.slave bus
);
  localparam int unsigned ADDR_W  = $clog2(LINE_NUM);
  localparam int unsigned PHT_NUM = 2 ** HIST_W;
  localparam int unsigned INIT_N  = (LINE_NUM > PHT_NUM) ? LINE_NUM : PHT_NUM;
  localparam int unsigned IDX_W   = $clog2(INIT_N);

  lhp_state_e       state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;

  logic [HIST_W-1:0] bht_q [LINE_NUM];

  logic              resp_valid_q, resp_valid_d;
  logic              resp_taken_q, resp_taken_d;
  logic [HIST_W-1:0] resp_hist_q, resp_hist_d;

  logic              init_bht_we, init_pht_we, upd_en, req_acc, rd_taken;
  logic [HIST_W-1:0] rd_hist, upd_bht_shift;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LHP_INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    busy       = 1'b0;
    unique case (state_q)
      LHP_INIT: begin
        busy = 1'b1;
        if (init_idx_q == IDX_W'(INIT_N - 1)) begin
          state_d    = LHP_RUN;
          init_idx_d = '0;
        end else begin
          init_idx_d = init_idx_q + IDX_W'(1);
        end
      end
      LHP_RUN: ;
    endcase
  end

  always_comb begin
    init_bht_we   = busy && (32'(init_idx_q) < LINE_NUM);
    init_pht_we   = busy && (32'(init_idx_q) < PHT_NUM);
    upd_en        = bus.upd_valid && !busy;
    req_acc       = bus.req_valid && !stall && !busy;
    upd_bht_shift = {bht_q[bus.upd_addr][HIST_W-2:0], bus.upd_taken};
  end

  always_ff @(posedge clk) begin
    if (init_bht_we) begin
      bht_q[init_idx_q[ADDR_W-1:0]] <= '0;
    end else if (upd_en) begin
      bht_q[bus.upd_addr] <= upd_bht_shift;
    end
  end

`ifdef LHP_BYPASS_EN
  always_comb rd_hist = (upd_en && (bus.upd_addr == bus.req_addr)) ? upd_bht_shift
                                                                   : bht_q[bus.req_addr];
`else
  always_comb rd_hist = bht_q[bus.req_addr];
`endif

  sat_counter_tbl #(
    .HIST_W (HIST_W),
    .CNT_W  (CNT_W)
  ) u_pht (
    .clk         (clk),
    .init_we_i   (init_pht_we),
    .init_idx_i  (init_idx_q[HIST_W-1:0]),
    .upd_we_i    (upd_en),
    .upd_idx_i   (bus.upd_hist),
    .upd_taken_i (bus.upd_taken),
    .rd_idx_i    (rd_hist),
    .rd_taken_o  (rd_taken)
  );

  // Stall freezes the whole response stage; updates still proceed.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_taken_d = resp_taken_q;
    resp_hist_d  = resp_hist_q;
    if (!stall) begin
      resp_valid_d = req_acc;
      if (req_acc) begin
        resp_taken_d = rd_taken;
        resp_hist_d  = rd_hist;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid_q <= 1'b0;
      resp_taken_q <= 1'b0;
      resp_hist_q  <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_taken_q <= resp_taken_d;
      resp_hist_q  <= resp_hist_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_taken = resp_taken_q;
  assign bus.resp_hist  = resp_hist_q;

endmodule

// File: tb/tb_local_hist_predictor.sv
// Scoreboard bench for local_hist_predictor (LINE_NUM=1024, HIST_W=6, CNT_W=2);
// follows LHP_BYPASS_EN the same way the design does.
module tb_local_hist_predictor;

  logic clk;
  logic rst;
  logic stall;
  logic busy;

  local_hist_predictor_if #(.ADDR_W(10), .HIST_W(6)) bus ();

  local_hist_predictor #(
    .LINE_NUM (1024),
    .HIST_W   (6),
    .CNT_W    (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .busy  (busy),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model
  typedef struct packed {
    logic [5:0] h;
    logic       t;
  } resp_t;

  logic [5:0]  m_bht [1024];
  logic [1:0]  m_pht [64];
  bit          m_busy = 1'b1;
  int unsigned m_idx  = 0;
  bit          m_rv   = 1'b0;
  bit          m_new  = 1'b0;
  resp_t       sbq[$];
  resp_t       m_exp;

  function automatic logic [1:0] cnt_step(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? 2'b11 : c + 2'd1;
    return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  always @(negedge rst) begin
    m_busy = 1'b1;
    m_idx  = 0;
    m_rv   = 1'b0;
    m_new  = 1'b0;
    sbq.delete();
  end

  always @(posedge clk) begin
    logic       acc;
    logic       upd;
    logic [5:0] h;
    logic [1:0] c;
    m_new = 1'b0;
    if (rst) begin
      acc = bus.req_valid && !stall && !m_busy;
      upd = bus.upd_valid && !m_busy;
      if (acc) begin
        h = m_bht[bus.req_addr];
        c = m_pht[h];
`ifdef LHP_BYPASS_EN
        if (upd && bus.upd_addr == bus.req_addr) h = {m_bht[bus.upd_addr][4:0], bus.upd_taken};
        c = (upd && bus.upd_hist == h) ? cnt_step(m_pht[h], bus.upd_taken) : m_pht[h];
`endif
        sbq.push_back('{h: h, t: c[1]});
      end
      if (!stall) begin
        m_rv  = acc;
        m_new = acc;
      end
      if (m_busy) begin
        if (m_idx < 1024) m_bht[m_idx] = 6'd0;
        if (m_idx < 64) m_pht[m_idx] = 2'b01;
        m_idx++;
        if (m_idx == 1024) m_busy = 1'b0;
      end else if (upd) begin
        m_bht[bus.upd_addr] = {m_bht[bus.upd_addr][4:0], bus.upd_taken};
        m_pht[bus.upd_hist] = cnt_step(m_pht[bus.upd_hist], bus.upd_taken);
      end
    end
  end

  // Monitor: sample 1 time unit after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        if (m_new) begin
          if (sbq.size() == 0) check_eq("sb_underflow", 32'(sbq.size()), 32'd1);
          else m_exp = sbq.pop_front();
        end
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("resp_valid", 32'(bus.resp_valid), 32'(m_rv));
        if (m_rv) begin
          check_eq("resp_hist", 32'(bus.resp_hist), 32'(m_exp.h));
          check_eq("resp_taken", 32'(bus.resp_taken), 32'(m_exp.t));
        end
      end
    end
  end

  task automatic drv(input logic rv, input logic [9:0] ra, input logic uv,
                     input logic [9:0] ua, input logic [5:0] uh, input logic ut,
                     input logic st);
    bus.req_valid = rv;
    bus.req_addr  = ra;
    bus.upd_valid = uv;
    bus.upd_addr  = ua;
    bus.upd_hist  = uh;
    bus.upd_taken = ut;
    stall         = st;
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drv(1'b0, 10'd0, 1'b0, 10'd0, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic reset_checks(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_rv"}, 32'(bus.resp_valid), 32'd0);
    check_eq({tag, "_rt"}, 32'(bus.resp_taken), 32'd0);
    check_eq({tag, "_rh"}, 32'(bus.resp_hist), 32'd0);
  endtask

  task automatic wait_init(input string tag);
    int unsigned n;
    n = 0;
    while (busy && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq(tag, n, 32'd1024);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = '0;
    bus.upd_valid = 1'b0; bus.upd_addr = '0; bus.upd_hist = '0; bus.upd_taken = 1'b0;
    stall = 1'b0;
    #2;
    reset_checks("por");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_init("init_cycles");

    // Fresh tables: history 0, weakly not taken
    drv(1'b1, 10'd5, 1'b0, 10'd0, 6'd0, 1'b0, 1'b0);
    idle(1);

    // Train addr 5 / PHT[0] taken, then saturate and walk back down
    repeat (3) drv(1'b0, 10'd0, 1'b1, 10'd5, 6'd0, 1'b1, 1'b0);
    drv(1'b1, 10'd5, 1'b0, 10'd0, 6'd0, 1'b0, 1'b0);
    drv(1'b1, 10'd6, 1'b0, 10'd0, 6'd0, 1'b0, 1'b0);
    drv(1'b0, 10'd0, 1'b1, 10'd20, 6'd0, 1'b1, 1'b0);
    drv(1'b1, 10'd6, 1'b0, 10'd0, 6'd0, 1'b0, 1'b0);
    drv(1'b0, 10'd0, 1'b1, 10'd21, 6'd0, 1'b0, 1'b0);
    drv(1'b1, 10'd6, 1'b0, 10'd0, 6'd0, 1'b0, 1'b0);
    drv(1'b0, 10'd0, 1'b1, 10'd21, 6'd0, 1'b0, 1'b0);
    drv(1'b1, 10'd6, 1'b0, 10'd0, 6'd0, 1'b0, 1'b0);
    idle(1);

    // Lookup 7, then stall 4 cycles with a competing request
    drv(1'b1, 10'd7, 1'b0, 10'd0, 6'd0, 1'b0, 1'b0);
    repeat (4) drv(1'b1, 10'd8, 1'b0, 10'd0, 6'd0, 1'b0, 1'b1);
    idle(2);

    // Same-cycle update and lookup of addr 9
    drv(1'b1, 10'd9, 1'b1, 10'd9, 6'd0, 1'b1, 1'b0);
    drv(1'b1, 10'd9, 1'b0, 10'd0, 6'd0, 1'b0, 1'b0);
    idle(1);

    // Reset, drive traffic during INIT (dropped), re-reset at index 300
    rst = 1'b0;
    #1;
    reset_checks("rst_run");
    @(negedge clk);
    rst = 1'b1;
    repeat (300) drv(1'b1, 10'd11, 1'b1, 10'd11, 6'd3, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    reset_checks("rst_mid_init");
    idle(2);
    rst = 1'b1;
    wait_init("reinit_cycles");
    drv(1'b1, 10'd11, 1'b0, 10'd0, 6'd0, 1'b0, 1'b0);
    drv(1'b1, 10'd5, 1'b0, 10'd0, 6'd0, 1'b0, 1'b0);
    idle(1);

    // Mixed random traffic over a small address window
    repeat (400) begin
      drv(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)),
          6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 4) == 0));
    end
    idle(2);

    // Reset while a response is valid
    drv(1'b1, 10'd3, 1'b0, 10'd0, 6'd0, 1'b0, 1'b0);
    check_eq("pre_rst_rv", 32'(bus.resp_valid), 32'd1);
    rst = 1'b0;
    #1;
    reset_checks("rst_resp");
    @(negedge clk);
    rst = 1'b1;
    wait_init("final_init_cycles");
    idle(2);
    check_eq("sb_leftover", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/local_hist_predictor.md
LOCAL_HIST_PREDICTOR -- requirements
Module: local_hist_predictor

Interface
REQ-001 SHALL have parameter LINE_NUM, default 1024, history-table entries (power of 2, >=4).
REQ-002 SHALL have parameter HIST_W, default 6, local history bits; PHT_NUM = 2**HIST_W derived.
REQ-003 SHALL have parameter CNT_W, default 2, saturating-counter width (>=2).
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port stall  in  1  freeze request/response pipeline.
REQ-007 SHALL have port req_valid  in  1  lookup request.
REQ-008 SHALL have port req_addr  in  clog2(LINE_NUM)  history-table index.
REQ-009 SHALL have port resp_valid  out  1  lookup result valid.
REQ-010 SHALL have port resp_taken  out  1  predicted direction (counter MSB).
REQ-011 SHALL have port resp_hist  out  HIST_W  history used for prediction.
REQ-012 SHALL have port upd_valid  in  1  resolved-branch update.
REQ-013 SHALL have port upd_addr  in  clog2(LINE_NUM)  history entry to shift.
REQ-014 SHALL have port upd_hist  in  HIST_W  history returned with the original prediction (PHT index).
REQ-015 SHALL have port upd_taken  in  1  actual outcome.
REQ-016 SHALL have port busy  out  1  table initialisation in progress.

Function
REQ-017 SHALL accept a lookup when req_valid & ~stall & ~busy; resp_valid=1 exactly one cycle later, 0 otherwise.
REQ-018 SHALL return resp_hist = BHT[req_addr] and resp_taken = PHT[BHT[req_addr]][CNT_W-1] as read in the accept cycle.
REQ-019 SHALL hold resp_valid, resp_taken, resp_hist unchanged while stall=1.
REQ-020 SHALL apply updates when upd_valid & ~busy, independent of stall: BHT[upd_addr] <= {BHT[upd_addr][HIST_W-2:0], upd_taken}; PHT[upd_hist] +1 if taken, -1 if not.
REQ-021 SHALL saturate counters at all-ones and zero; no wrap.
REQ-022 SHALL drop updates and lookups while busy=1.
REQ-023 SHALL implement FSM states INIT and RUN; INIT writes one BHT entry (0) and one PHT entry (01..0 weakly-not-taken) per cycle, index 0 upward.
REQ-024 SHALL leave INIT for RUN after max(LINE_NUM,PHT_NUM) cycles; busy=1 exactly in INIT.
REQ-025 SHALL, for simultaneous update and lookup to the same entry, return pre-update values (unless REQ-029).

Reset
REQ-026 SHALL on rst=0 immediately force FSM=INIT, init index=0, busy=1, resp_valid=0, resp_taken=0, resp_hist=0.
REQ-027 SHALL restart initialisation from index 0 if rst asserts mid-INIT or mid-operation.
REQ-028 SHALL not reset table storage asynchronously; tables are cleared only by INIT.

Configuration
REQ-029 SHALL, with LHP_BYPASS_EN defined, forward same-cycle update to a same-index lookup (post-shift history, post-update counter); without it, REQ-025 holds and no forwarding logic exists.

Structure
REQ-030 SHALL place counter-update function, FSM state encoding and weakly-not-taken constant in shared package bp_pkg.
REQ-031 SHALL use one sub-module sat_counter_tbl (PHT storage plus saturating update).

Verification
REQ-032 SHALL cover: reset release, LINE_NUM=1024, HIST_W=6 -> busy=1 for 1024 cycles, then 0; lookup addr 5 -> resp_hist=0, resp_taken=0.
REQ-033 SHALL cover: 3 updates addr 5 taken, upd_hist=0 -> BHT[5]=6'b000111; PHT[0]=2'b11, one more taken stays 2'b11.
REQ-034 SHALL cover: lookup addr 7 then stall=1 for 4 cycles -> resp_* held; new req during stall not accepted.
REQ-035 SHALL cover: same-cycle update addr 9 taken and lookup addr 9 -> resp_hist=0 without LHP_BYPASS_EN, 6'b000001 with it.
REQ-036 SHALL cover: rst pulse at init index 300 -> busy stays 1, index restarts at 0, completes 1024 cycles later.
